// File: rtl/hazard_pkg.sv
// Shared types and encodings for the multi-cycle hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        FREEZE = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_WB = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/hazard_ctrl_mc_fwd_sel.sv
// Per-operand forward selector: MEM result has priority over WB result; x0 is never forwarded.
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 4
) (
    input  logic [REG_ADDR_W-1:0] i_rs_EX,
    input  logic [REG_ADDR_W-1:0] i_rdAddr_M,
    input  logic                  i_reg_write_M,
    input  logic [REG_ADDR_W-1:0] i_rdAddr_WB,
    input  logic                  i_reg_write_WB,
    output logic [1:0]            o_fwd
);

    always_comb begin
        o_fwd = FWD_RF;
        if (i_reg_write_M && (i_rdAddr_M != '0) && (i_rdAddr_M == i_rs_EX)) begin
            o_fwd = FWD_M;
        end else if (i_reg_write_WB && (i_rdAddr_WB != '0) && (i_rdAddr_WB == i_rs_EX)) begin
            o_fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Multi-cycle hazard controller: forwarding, load-use stall of configurable depth,
// memory-wait freeze with lcnt preserved across it, and branch flush deferred past a freeze.
module hazard_ctrl_mc
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 4,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] i_rs1Addr_ID,
    input  logic [REG_ADDR_W-1:0] i_rs2Addr_ID,
    input  logic [REG_ADDR_W-1:0] i_rs1Addr_EX,
    input  logic [REG_ADDR_W-1:0] i_rs2Addr_EX,
    input  logic [REG_ADDR_W-1:0] i_rdAddr_EX,
    input  logic [1:0]            i_result_src_EX,
    input  logic                  i_pcSrc_EX,
    input  logic [REG_ADDR_W-1:0] i_rdAddr_M,
    input  logic                  i_reg_write_M,
    input  logic [REG_ADDR_W-1:0] i_rdAddr_WB,
    input  logic                  i_reg_write_WB,
    input  logic                  i_mem_busy,
    output logic                  o_stall_IF,
    output logic                  o_stall_ID,
    output logic                  o_stall_EX,
    output logic                  o_stall_M,
    output logic                  o_flush_ID,
    output logic                  o_flush_EX,
    output logic [1:0]            o_forward_rs1_EX,
    output logic [1:0]            o_forward_rs2_EX,
    output logic [CNT_W-1:0]      o_stall_cnt,
    output logic [1:0]            o_state
);

    state_t           r_state;
    logic [2:0]       r_lcnt;
    logic [CNT_W-1:0] r_stall_cnt;

    state_t     w_next_state;
    state_t     w_eff_state;
    state_t     w_dbg_state;
    logic [2:0] w_next_lcnt;
    logic       w_lu;
    logic       w_stall_IF;
    logic       w_stall_ID;
    logic       w_stall_EX;
    logic       w_stall_M;
    logic       w_flush_ID;
    logic       w_flush_EX;
    logic [1:0] w_fwd_rs1;
    logic [1:0] w_fwd_rs2;

    fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
        .i_rs_EX        (i_rs1Addr_EX),
        .i_rdAddr_M     (i_rdAddr_M),
        .i_reg_write_M  (i_reg_write_M),
        .i_rdAddr_WB    (i_rdAddr_WB),
        .i_reg_write_WB (i_reg_write_WB),
        .o_fwd          (w_fwd_rs1)
    );

    fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
        .i_rs_EX        (i_rs2Addr_EX),
        .i_rdAddr_M     (i_rdAddr_M),
        .i_reg_write_M  (i_reg_write_M),
        .i_rdAddr_WB    (i_rdAddr_WB),
        .i_reg_write_WB (i_reg_write_WB),
        .o_fwd          (w_fwd_rs2)
    );

    assign w_lu = (i_result_src_EX == RESULT_SRC_LOAD) && (i_rdAddr_EX != '0) &&
                  ((i_rdAddr_EX == i_rs1Addr_ID) || (i_rdAddr_EX == i_rs2Addr_ID));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RUN;
            r_lcnt      <= 3'd0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            r_lcnt  <= w_next_lcnt;
            if (w_stall_IF) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    // A registered FREEZE only means "frozen last cycle": once i_mem_busy drops, this
    // cycle already behaves as the resumed state, so a held branch flushes with no gap.
    always_comb begin
        w_eff_state  = (r_state == FREEZE) ? ((r_lcnt != 3'd0) ? LSTALL : RUN) : r_state;
        w_dbg_state  = w_eff_state;
        w_next_state = w_eff_state;
        w_next_lcnt  = r_lcnt;
        w_stall_IF   = 1'b0;
        w_stall_ID   = 1'b0;
        w_stall_EX   = 1'b0;
        w_stall_M    = 1'b0;
        w_flush_ID   = 1'b0;
        w_flush_EX   = 1'b0;
        if (rst) begin
            w_dbg_state  = RUN;
            w_next_state = RUN;
        end else if (i_mem_busy) begin
            w_dbg_state  = FREEZE;
            w_next_state = FREEZE;
            w_stall_IF   = 1'b1;
            w_stall_ID   = 1'b1;
            w_stall_EX   = 1'b1;
            w_stall_M    = 1'b1;
        end else begin
            case (w_eff_state)
                LSTALL: begin
                    if (i_pcSrc_EX) begin
                        w_flush_ID   = 1'b1;
                        w_flush_EX   = 1'b1;
                        w_next_lcnt  = 3'd0;
                        w_next_state = RUN;
                    end else begin
                        w_stall_IF = 1'b1;
                        w_stall_ID = 1'b1;
                        w_flush_EX = 1'b1;
                        if (r_lcnt <= 3'd1) begin
                            w_next_lcnt  = 3'd0;
                            w_next_state = RUN;
                        end else begin
                            w_next_lcnt  = r_lcnt - 3'd1;
                            w_next_state = LSTALL;
                        end
                    end
                end
                default: begin
                    w_next_state = RUN;
                    if (i_pcSrc_EX) begin
                        w_flush_ID = 1'b1;
                        w_flush_EX = 1'b1;
                    end else if (w_lu) begin
                        w_stall_IF = 1'b1;
                        w_stall_ID = 1'b1;
                        w_flush_EX = 1'b1;
                        if (LOAD_STALL > 1) begin
                            w_next_lcnt  = 3'(LOAD_STALL - 1);
                            w_next_state = LSTALL;
                        end
                    end
                end
            endcase
        end
    end

    assign o_stall_IF       = w_stall_IF;
    assign o_stall_ID       = w_stall_ID;
    assign o_stall_EX       = w_stall_EX;
    assign o_stall_M        = w_stall_M;
    assign o_flush_ID       = w_flush_ID;
    assign o_flush_EX       = w_flush_EX;
    assign o_forward_rs1_EX = rst ? FWD_RF : w_fwd_rs1;
    assign o_forward_rs2_EX = rst ? FWD_RF : w_fwd_rs2;
    assign o_stall_cnt      = r_stall_cnt;
    assign o_state          = w_dbg_state;

endmodule
